// File: rtl/vid_pkg.sv
// Shared video types: pixel layout, raster phase encoding, sync polarity and colour-bar lookup.
// Optional VID_TEST_PATTERN_EN build uses bar_color() for the test pattern.
package vid_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} sync_state;

   localparam logic SYNC_ACT_LOW  = 1'b0;
   localparam logic SYNC_ACT_HIGH = 1'b1;

   // Bar order white, yellow, cyan, green, magenta, red, blue, black.
   function automatic pixel_t bar_color(input logic [2:0] idx);
      pixel_t p;
      p.r = {8{~idx[1]}};
      p.g = {8{~idx[2]}};
      p.b = {8{~idx[0]}};
      return p;
   endfunction

endpackage

// File: rtl/vid_axis_counter.sv
// One raster axis: position counter with phase decode (active, porch, sync), zero-latency flags.
// Backpressure: none; advances whenever i_cnt_en is high, i_clr forces position 0.
module vid_axis_counter
   import vid_pkg::*;
#(
   parameter int ACTIVE_LEN = 640,
   parameter int FP_LEN     = 16,
   parameter int SYNC_LEN   = 96,
   parameter int BP_LEN     = 48,
   localparam int TOTAL     = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN,
   localparam int CW        = $clog2(TOTAL)
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_cnt_en,
   input  logic          i_clr,
   output logic [CW-1:0] o_cnt,
   output logic          o_wrap,
   output logic          o_active,
   output logic          o_sync
);

   localparam logic [CW-1:0] C_FP_START   = CW'(ACTIVE_LEN);
   localparam logic [CW-1:0] C_SYNC_START = CW'(ACTIVE_LEN + FP_LEN);
   localparam logic [CW-1:0] C_BP_START   = CW'(ACTIVE_LEN + FP_LEN + SYNC_LEN);
   localparam logic [CW-1:0] C_LAST       = CW'(TOTAL - 1);

   logic [CW-1:0] r_cnt;
   sync_state     w_state;

   assign o_wrap = i_cnt_en & (r_cnt == C_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clr || o_wrap) begin
         r_cnt <= '0;
      end else if (i_cnt_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state = BP;
      if (r_cnt < C_FP_START)        w_state = ACTIVE;
      else if (r_cnt < C_SYNC_START) w_state = FP;
      else if (r_cnt < C_BP_START)   w_state = SYNC;
   end

   assign o_cnt    = r_cnt;
   assign o_active = (w_state == ACTIVE);
   assign o_sync   = (w_state == SYNC);

endmodule

// File: rtl/vid_timing_out.sv
// Raster timing + pixel pop from FIFO; all video outputs registered, 1 clk after counter state.
// Backpressure: none, raster never stalls (empty FIFO -> black + sticky underflow); VID_TEST_PATTERN_EN adds pattern_sel.
module vid_timing_out
   import vid_pkg::*;
#(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = SYNC_ACT_LOW
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [23:0] fifo_data,
   input  logic        fifo_empty,
`ifdef VID_TEST_PATTERN_EN
   input  logic        pattern_sel,
`endif
   input  logic        underflow_clr,
   output logic        fifo_rd,
   output logic        hsync,
   output logic        hblank,
   output logic        vsync,
   output logic        vblank,
   output logic [7:0]  R,
   output logic [7:0]  G,
   output logic [7:0]  B,
   output logic        frame_start,
   output logic        underflow
);

   localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int   H_CW     = $clog2(H_TOTAL);
   localparam int   V_CW     = $clog2(V_TOTAL);
   localparam logic SYNC_ON  = SYNC_POL;
   localparam logic SYNC_OFF = (SYNC_POL == SYNC_ACT_HIGH) ? 1'b0 : 1'b1;

   logic [H_CW-1:0] w_h_cnt;
   logic [V_CW-1:0] w_v_cnt;
   logic            w_h_wrap;
   logic            w_v_wrap_unused;
   logic            w_h_active;
   logic            w_v_active;
   logic            w_h_sync;
   logic            w_v_sync;
   logic            w_active;
   logic            w_fifo_src;
   logic            w_uf_set;
   logic            w_origin;
   pixel_t          w_pix_nxt;

   logic            r_hsync;
   logic            r_vsync;
   logic            r_hblank;
   logic            r_vblank;
   pixel_t          r_pix;
   logic            r_frame_start;
   logic            r_underflow;

   vid_axis_counter #(
      .ACTIVE_LEN (H_ACTIVE),
      .FP_LEN     (H_FP),
      .SYNC_LEN   (H_SYNC),
      .BP_LEN     (H_BP)
   ) u_h_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_cnt_en (enable),
      .i_clr    (~enable),
      .o_cnt    (w_h_cnt),
      .o_wrap   (w_h_wrap),
      .o_active (w_h_active),
      .o_sync   (w_h_sync)
   );

   vid_axis_counter #(
      .ACTIVE_LEN (V_ACTIVE),
      .FP_LEN     (V_FP),
      .SYNC_LEN   (V_SYNC),
      .BP_LEN     (V_BP)
   ) u_v_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_cnt_en (enable & w_h_wrap),
      .i_clr    (~enable),
      .o_cnt    (w_v_cnt),
      .o_wrap   (w_v_wrap_unused),
      .o_active (w_v_active),
      .o_sync   (w_v_sync)
   );

`ifdef VID_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
   assign w_fifo_src = ~pattern_sel;
`else
   assign w_fifo_src = 1'b1;
`endif

   assign w_active = w_h_active & w_v_active;
   assign w_origin = (w_h_cnt == '0) & (w_v_cnt == '0);
   assign fifo_rd  = enable & w_active & ~fifo_empty & w_fifo_src;
   assign w_uf_set = enable & w_active & fifo_empty & w_fifo_src;

   always_comb begin
      w_pix_nxt = '0;
      if (fifo_rd) w_pix_nxt = pixel_t'(fifo_data);
`ifdef VID_TEST_PATTERN_EN
      if (enable & w_active & pattern_sel)
         w_pix_nxt = bar_color(3'(int'(w_h_cnt) / BAR_W));
`endif
   end

   // Dropping enable parks the outputs exactly as reset does; underflow lives in its own process.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hsync       <= SYNC_OFF;
         r_vsync       <= SYNC_OFF;
         r_hblank      <= 1'b1;
         r_vblank      <= 1'b1;
         r_pix         <= '0;
         r_frame_start <= 1'b0;
      end else if (!enable) begin
         r_hsync       <= SYNC_OFF;
         r_vsync       <= SYNC_OFF;
         r_hblank      <= 1'b1;
         r_vblank      <= 1'b1;
         r_pix         <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_hsync       <= w_h_sync ? SYNC_ON : SYNC_OFF;
         r_vsync       <= w_v_sync ? SYNC_ON : SYNC_OFF;
         r_hblank      <= ~w_h_active;
         r_vblank      <= ~w_v_active;
         r_pix         <= w_pix_nxt;
         r_frame_start <= w_origin;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_underflow <= 1'b0;
      end else if (w_uf_set) begin
         r_underflow <= 1'b1;
      end else if (underflow_clr) begin
         r_underflow <= 1'b0;
      end
   end

   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign hblank      = r_hblank;
   assign vblank      = r_vblank;
   assign R           = r_pix.r;
   assign G           = r_pix.g;
   assign B           = r_pix.b;
   assign frame_start = r_frame_start;
   assign underflow   = r_underflow;

endmodule

// File: tb/tb_vid_timing_out.sv
// Randomized bench for vid_timing_out on a tiny 8x6 raster against a position-arithmetic reference model.
module tb_vid_timing_out;

   localparam int   HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int   VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int   HT = HA + HF + HS + HB;
   localparam int   VT = VA + VF + VS + VB;
   localparam int   FT = HT * VT;
   localparam logic SP = 1'b0;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        enable = 1'b0;
   logic [23:0] fifo_data = 24'h0;
   logic        fifo_empty = 1'b1;
   logic        underflow_clr = 1'b0;

   logic        fifo_rd, hsync, hblank, vsync, vblank, frame_start, underflow;
   logic [7:0]  R, G, B;

   vid_timing_out #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SYNC_POL (SP)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .fifo_data     (fifo_data),
      .fifo_empty    (fifo_empty),
`ifdef VID_TEST_PATTERN_EN
      .pattern_sel   (1'b0),
`endif
      .underflow_clr (underflow_clr),
      .fifo_rd       (fifo_rd),
      .hsync         (hsync),
      .hblank        (hblank),
      .vsync         (vsync),
      .vblank        (vblank),
      .R             (R),
      .G             (G),
      .B             (B),
      .frame_start   (frame_start),
      .underflow     (underflow)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [23:0] q[$];
   logic [23:0] next_pix = 24'h1;
   bit          seq_mode = 1'b1;
   int          t = 0;
   logic        e_hb = 1'b1, e_vb = 1'b1, e_hs = ~SP, e_vs = ~SP, e_fs = 1'b0, e_uf = 1'b0;
   logic [23:0] e_rgb = 24'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outs();
      chk("hblank",      32'(hblank),      32'(e_hb));
      chk("vblank",      32'(vblank),      32'(e_vb));
      chk("hsync",       32'(hsync),       32'(e_hs));
      chk("vsync",       32'(vsync),       32'(e_vs));
      chk("rgb",         32'({R, G, B}),   32'(e_rgb));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("underflow",   32'(underflow),   32'(e_uf));
   endtask

   task automatic park_model();
      e_hb = 1'b1; e_vb = 1'b1; e_hs = ~SP; e_vs = ~SP;
      e_rgb = 24'h0; e_fs = 1'b0; t = 0;
   endtask

   task automatic refill();
      while (q.size() < 4) begin
         if (seq_mode) begin
            q.push_back(next_pix);
            next_pix++;
         end else begin
            q.push_back(24'($urandom));
         end
      end
   endtask

   // One clock: check last edge's outputs, drive inputs, predict the next edge.
   task automatic step(input bit en, input bit force_empty, input bit clr);
      int h, v;
      bit act, pop, in_hs, in_vs;
      @(negedge clk);
      check_outs();
      refill();
      enable        = en;
      underflow_clr = clr;
      fifo_empty    = force_empty;
      fifo_data     = force_empty ? 24'($urandom) : q[0];
      #1;
      h   = t % HT;
      v   = (t / HT) % VT;
      act = en && (h < HA) && (v < VA);
      pop = act && !force_empty;
      chk("fifo_rd", 32'(fifo_rd), 32'(pop));
      if (!en) begin
         park_model();
      end else begin
         in_hs = (h >= HA + HF) && (h < HA + HF + HS);
         in_vs = (v >= VA + VF) && (v < VA + VF + VS);
         e_hb  = (h >= HA);
         e_vb  = (v >= VA);
         e_hs  = in_hs ? SP : ~SP;
         e_vs  = in_vs ? SP : ~SP;
         e_rgb = pop ? q[0] : 24'h0;
         e_fs  = (t == 0);
         t     = (t + 1) % FT;
      end
      if (act && force_empty) e_uf = 1'b1;
      else if (clr)           e_uf = 1'b0;
      if (pop) void'(q.pop_front());
   endtask

   initial begin
      bit en_r;
      #1 reset_n = 1'b0;
      #2;
      check_outs();
      chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Two full frames of sequential pixels 1,2,3,...
      repeat (2 * FT) step(1'b1, 1'b0, 1'b0);

      // Starve the 3rd active pixel of line 0, then clear underflow.
      while (t != 2) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      repeat (2) step(1'b1, 1'b0, 1'b0);

      // Drop enable at (h=2, v=1), then restart.
      while (t != HT + 2) step(1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      repeat (FT + 4) step(1'b1, 1'b0, 1'b0);

      // Async reset mid-line with underflow set and a live pixel showing.
      while (t != 1) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      park_model();
      e_uf = 1'b0;
      check_outs();
      enable = 1'b0;
      underflow_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (FT + 10) step(1'b1, 1'b0, 1'b0);

      // Random enable gaps, FIFO starvation and clears with random pixel data.
      seq_mode = 1'b0;
      en_r = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if (en_r) begin
            if ($urandom_range(0, 99) < 2) en_r = 1'b0;
         end else begin
            if ($urandom_range(0, 99) < 30) en_r = 1'b1;
         end
         step(en_r, ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 5));
      end
      step(1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
